// File: rtl/rd_alu_arbiter.sv
// rd_alu_arbiter: round-robin two-requester front end for the shared ALU.
// Issue stage drives the ALU; response stage returns results in grant order.
module rd_alu_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [1:0][3:0]        req_op_i,
  input  logic [1:0][XLEN-1:0]   req_a_i,
  input  logic [1:0][XLEN-1:0]   req_b_i,
  input  logic [1:0][TAG_W-1:0]  req_tag_i,
  output logic [3:0]             alu_ctrl_o,
  output logic [XLEN-1:0]        alu_a_o,
  output logic [XLEN-1:0]        alu_b_o,
  input  logic [XLEN-1:0]        alu_result_i,
  output logic [1:0]             rsp_valid_o,
  input  logic [1:0]             rsp_ready_i,
  output logic [XLEN-1:0]        rsp_data_o,
  output logic [TAG_W-1:0]       rsp_tag_o,
  output logic                   rsp_illegal_o
);

  typedef struct packed {
    logic             owner;
    logic [3:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
  } iss_t;

  typedef struct packed {
    logic             owner;
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } rsp_t;

  logic       s1_valid;
  iss_t       s1;
  logic       s2_valid;
  rsp_t       s2;
  logic       rr_ptr;
  logic       s1_free;
  logic       s2_free;
  logic [1:0] gnt;
  logic       gnt_any;
  logic       win;

  assign s2_free = !s2_valid | rsp_ready_i[s2.owner];
  assign s1_free = !s1_valid | s2_free;
  assign gnt_any = |gnt;

  // Pick a winner; both valid falls back to the round-robin pointer
  always_comb begin
    gnt = 2'b00;
    win = 1'b0;
    if (s1_free) begin
      unique case (req_valid_i)
        2'b01:   win = 1'b0;
        2'b10:   win = 1'b1;
        2'b11:   win = rr_ptr;
        default: win = 1'b0;
      endcase
      if (|req_valid_i)
        gnt = win ? 2'b10 : 2'b01;
    end
  end

  // Pointer moves to the loser only when a grant is taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      rr_ptr <= 1'b0;
    else if (gnt_any)
      rr_ptr <= ~win;
  end

  // Issue stage: load winner, or go empty when free with no grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (gnt_any) begin
      s1_valid <= 1'b1;
      s1.owner <= win;
      s1.op    <= req_op_i[win];
      s1.a     <= req_a_i[win];
      s1.b     <= req_b_i[win];
      s1.tag   <= req_tag_i[win];
    end else if (s1_free) begin
      s1_valid <= 1'b0;
    end
  end

  // Response stage: capture ALU result as the issue stage advances
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (s1_valid && s2_free) begin
      s2_valid <= 1'b1;
      s2.owner <= s1.owner;
      s2.res   <= alu_result_i;
      s2.tag   <= s1.tag;
      s2.ill   <= (s1.op == 4'b1111);
    end else if (s2_free) begin
      s2_valid <= 1'b0;
    end
  end

  // Output drive straight from stage registers
  always_comb begin
    req_ready_o    = gnt;
    alu_ctrl_o     = s1.op;
    alu_a_o        = s1.a;
    alu_b_o        = s1.b;
    rsp_valid_o[0] = s2_valid & ~s2.owner;
    rsp_valid_o[1] = s2_valid & s2.owner;
    rsp_data_o     = s2.res;
    rsp_tag_o      = s2.tag;
    rsp_illegal_o  = s2.ill;
  end

endmodule
